rot_frame_capture: RTL
======================

// Module: rot_frame_capture
// PURPOSE
//   Synthesizable sink for the rotated-image output stream (Start_out/H_Valid_out/H_Jump_out/R_Bmp_Data).
//   Realigns the stream through a fixed input delay, tracks column/row, and writes every pixel into a
//   linear frame-buffer write port (pixel k -> address k). Pulses frame_done after W*H pixels.
//   Flags framing errors. Replaces bench-only collection so on-chip capture and readback are possible.
// PARAMETERS
//   W        256  pixels per line
//   H        256  lines per frame
//   PIX_W    24   pixel width, RGB888
//   ADDR_W   20   frame-buffer address width; must satisfy 2**ADDR_W >= W*H
//   PIPE_DLY 2    register stages applied equally to all stream inputs before decode; range 1..4
// PORTS
//   Clk_in       in   1       sole clock; the stream is sampled on its rising edge
//   Reset        in   1       synchronous, active-high reset
//   Start_out    in   1       one-cycle strobe; the same cycle carries valid pixel 0 of a frame
//   H_Valid_out  in   1       valid pixel (not pixel 0) on R_Bmp_Data this cycle
//   H_Jump_out   in   1       line-boundary strobe; arrives in a non-valid cycle after a line's last pixel
//   R_Bmp_Data   in   PIX_W   pixel data
//   mem_we       out  1       frame-buffer write strobe
//   mem_addr     out  ADDR_W  write address = linear pixel index
//   mem_data     out  PIX_W   write data
//   busy         out  1       high in CAPTURE
//   frame_done   out  1       one-cycle pulse, coincident with the write of pixel W*H-1
//   pix_cnt      out  ADDR_W  pixels written in the current or last frame
//   err_line     out  1       sticky: H_Jump seen with column count != W
//   err_stray    out  1       sticky: H_Valid or H_Jump seen while not in CAPTURE
//   err_restart  out  1       sticky: Start seen during CAPTURE (frame aborted)
// BEHAVIOUR
//   - Reset: every output is 0, col/row/pix_cnt are 0, delay lines are cleared, state is IDLE.
//     Reset applies mid-frame with no write of the pending pixel.
//   - Input stage: Start/H_Valid/H_Jump/data pass together through PIPE_DLY regs ("_d" signals).
//     mem_* are registered from the _d stage.
//     Latency: a pixel sampled at edge t produces mem_we high in the cycle after edge t+PIPE_DLY.
//   - FSM: IDLE, CAPTURE, DONE.
//       IDLE    : Start_d -> write addr 0, col=1, pix_cnt=1 -> CAPTURE.
//                 H_Valid_d or H_Jump_d -> set err_stray, no write.
//       CAPTURE : H_Valid_d -> write addr pix_cnt; pix_cnt++, col++.
//                 H_Jump_d -> if col != W set err_line; col=0, row++.
//                 Start_d -> set err_restart, restart at addr 0 (identical to IDLE+Start).
//                 Write of pixel W*H-1 -> frame_done=1 that cycle -> DONE.
//       DONE    : one cycle, busy=0, then IDLE. Start_d here is treated as IDLE+Start.
//                 H_Valid_d here sets err_stray.
//   - Simultaneous inputs: Start_d with H_Valid_d is one pixel (pixel 0).
//     H_Jump_d coinciding with H_Valid_d or Start_d: the pixel is written and err_line is set.
//   - Address generation is an incrementing counter; no multiplier. Address wraps never, because
//     the frame ends at W*H-1. Lines longer than W keep writing linearly and set err_line at the next H_Jump.
//   - The final line needs no H_Jump; a trailing H_Jump after DONE sets err_stray.
//   - mem_we is high only in a write cycle; mem_addr/mem_data hold their last value otherwise.
//   - All err_* flags clear only on Reset.
// STRUCTURE
//   - Shared package img_pkg: W, H, PIX_W, ADDR_W defaults; localparam FRAME_PIX = W*H;
//     state encoding typedef cap_state_t {IDLE, CAPTURE, DONE}.
//   - One sub-module: stream_delay_line (params WIDTH, DEPTH, synchronous reset to 0).
//     Instantiated once on the {Start, H_Valid, H_Jump, data} bundle.
// TESTING  (use W=4,H=4,PIPE_DLY=2 unless noted)
//   - Clean frame: Start + 15 H_Valid, H_Jump after every 4th pixel, data = 0x100000+k ->
//     16 writes, addr k / data 0x100000+k; frame_done with addr 15; first mem_we 3 cycles after Start.
//     No err_* set.
//   - Short line: 2nd line only 3 pixels before H_Jump -> err_line=1 at that H_Jump.
//     Writes stay linear; frame_done after 16 total pixels.
//   - Stray and restart: H_Valid while IDLE -> err_stray=1, no mem_we. Start after pixel 6 ->
//     err_restart=1, next write at addr 0, pix_cnt=1.
//   - Reset mid-frame: assert Reset after pixel 9 for 1 cycle -> all outputs 0, state IDLE.
//     Following clean frame completes normally.
//   - Back-to-back frames: Start in the DONE cycle -> second frame captured with no missed pixel,
//     two frame_done pulses.
//   - Full size W=H=256: lena stream -> 65536 writes, last addr 0xFFFF with frame_done.
//     Memory dump matches the golden rotated image.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and defaults for the rotated-image capture path.
// Frame geometry, pixel/address widths and the capture FSM encoding.
package img_pkg;

    localparam int W         = 256;
    localparam int H         = 256;
    localparam int PIX_W     = 24;
    localparam int ADDR_W    = 20;
    localparam int FRAME_PIX = W * H;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/stream_delay_line.sv
// Fixed-depth register chain, cleared by synchronous reset.
// Ports: Clk_in, Reset (sync, active high), din[WIDTH], dout[WIDTH] (din delayed DEPTH cycles).
module stream_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             Clk_in,
    input  logic             Reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/rot_frame_capture.sv
// Captures the rotated-image stream into a linear frame-buffer write port.
// Ports: Clk_in, Reset (sync, active high); stream in: Start_out, H_Valid_out,
//   H_Jump_out, R_Bmp_Data; write port out: mem_we, mem_addr, mem_data;
//   status out: busy, frame_done, pix_cnt, err_line, err_stray, err_restart.
module rot_frame_capture #(
    parameter int W        = img_pkg::W,
    parameter int H        = img_pkg::H,
    parameter int PIX_W    = img_pkg::PIX_W,
    parameter int ADDR_W   = img_pkg::ADDR_W,
    parameter int PIPE_DLY = 2
) (
    input  logic              Clk_in,
    input  logic              Reset,
    input  logic              Start_out,
    input  logic              H_Valid_out,
    input  logic              H_Jump_out,
    input  logic [PIX_W-1:0]  R_Bmp_Data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_data,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pix_cnt,
    output logic              err_line,
    output logic              err_stray,
    output logic              err_restart
);

    import img_pkg::cap_state_t;
    import img_pkg::IDLE;
    import img_pkg::CAPTURE;
    import img_pkg::DONE;

    localparam int                BW     = PIX_W + 3;
    localparam int                NPIX   = W * H;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] LINE_N = ADDR_W'(W);

    logic              start_d;
    logic              hv_d;
    logic              hj_d;
    logic [PIX_W-1:0]  data_d;

    cap_state_t        state;
    cap_state_t        state_nx;
    logic [ADDR_W-1:0] col;

    logic              in_cap;
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic              last;
    logic              set_line;
    logic              set_stray;
    logic              set_restart;

    stream_delay_line #(
        .WIDTH (BW),
        .DEPTH (PIPE_DLY)
    ) u_dly (
        .Clk_in (Clk_in),
        .Reset  (Reset),
        .din    ({Start_out, H_Valid_out, H_Jump_out, R_Bmp_Data}),
        .dout   ({start_d, hv_d, hj_d, data_d})
    );

    // State register
    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; a Start always (re)enters CAPTURE, the last pixel wins
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start_d ? CAPTURE : IDLE;
            CAPTURE: state_nx = CAPTURE;
            DONE:    state_nx = start_d ? CAPTURE : IDLE;
            default: state_nx = IDLE;
        endcase
        if (last) begin
            state_nx = DONE;
        end
    end

    // Decode: write strobe, address and error events for this cycle.
    // Start carries pixel 0 in any state, so it never counts as stray.
    always_comb begin
        in_cap      = (state == CAPTURE);
        wr          = start_d | (in_cap & hv_d);
        wr_addr     = start_d ? '0 : pix_cnt;
        last        = wr && (wr_addr == LAST_A);
        set_restart = start_d & in_cap;
        set_stray   = ~start_d & ~in_cap & (hv_d | hj_d);
        set_line    = hj_d & (start_d | (in_cap & (hv_d | (col != LINE_N))));
    end

    assign busy = (state == CAPTURE);

    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            frame_done  <= 1'b0;
            pix_cnt     <= '0;
            col         <= '0;
            err_line    <= 1'b0;
            err_stray   <= 1'b0;
            err_restart <= 1'b0;
        end else begin
            mem_we     <= wr;
            frame_done <= last;
            if (wr) begin
                mem_addr <= wr_addr;
                mem_data <= data_d;
                pix_cnt  <= wr_addr + 1'b1;
            end
            if (hj_d && (start_d || in_cap)) begin
                col <= '0;
            end else if (start_d) begin
                col <= ADDR_W'(1);
            end else if (in_cap && hv_d) begin
                col <= col + 1'b1;
            end
            err_line    <= err_line | set_line;
            err_stray   <= err_stray | set_stray;
            err_restart <= err_restart | set_restart;
        end
    end

endmodule
